fp_wb_stage: RTL and testbench
==============================

# fp_wb_stage

Writeback/retire stage placed directly downstream of the FP arithmetic units (fp_div, fp_add/fp_mul through fp_rnd). It accepts one rounded result plus its status_t flags per cycle over a valid/ready handshake, NaN-boxes narrow-format results to 64 bits, and buffers them in a small FIFO. It presents them in order to the register-file writer and accumulates sticky exception flags (fflags) as each entry retires.

## Interface

Parameters:
- FP_FORMAT, FP32, format of incoming results (fp_format_e from fp_pkg); sets NaN-box width.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- TAG_W, 5, width of destination tag carried alongside each result.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- in_valid_i  in  1  upstream result valid.
- in_ready_o  out  1  stage can accept; equals !full; no combinational dependence on out_ready_i.
- in_result_i  in  64  rounded result (rnd_result.result); only low FP width used.
- in_flags_i  in  status_t  rounded flags {NV,DZ,OF,UF,NX} (rnd_result.flags).
- in_tag_i  in  TAG_W  destination tag.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  consumer accepts head.
- out_result_o  out  64  NaN-boxed head result.
- out_flags_o  out  status_t  head flags.
- out_tag_o  out  TAG_W  head tag.
- fflags_o  out  5  sticky accumulated flags.
- fflags_we_i  in  1  CSR write strobe.
- fflags_wdata_i  in  5  CSR write data.
- count_o  out  $clog2(DEPTH)+1  occupancy.

## Operation

- Push: in_valid_i && in_ready_o. Pop: out_valid_o && out_ready_i.
- Boxing at enqueue: FP32 → {32'hFFFF_FFFF, in_result_i[31:0]}; FP16 → {48 ones, [15:0]}; FP64 → unchanged.
- FIFO: write pointer, read pointer, count; pointers wrap modulo DEPTH; in-order only.
- Simultaneous push+pop, non-empty and non-full: count unchanged, both pointers advance.
- Full: in_ready_o=0 even if a pop occurs that cycle; push is ignored.
- Empty: out_valid_o=0; out_result_o, out_flags_o and out_tag_o are driven to 0, never stale data. There is no bypass: a pushed entry appears on the next cycle.
- In-valid while not ready: upstream holds its data. The stage is not required to tolerate data change.
- fflags next value = (fflags_we_i ? fflags_wdata_i : fflags_o) | (pop ? out_flags_o : 0).
  - Flags accrue only at retire, never at enqueue.
  - A CSR write and a retire in the same cycle both take effect.
- Reset mid-operation: all entries are discarded. Pointers=0, count=0, fflags=0, out_valid_o=0, in_ready_o=1 from the cycle after rst_i is sampled high. A push or CSR write in the reset cycle is ignored.

## Timing

- Latency in→out: 1 cycle minimum; out_valid_o rises the cycle after the first push into an empty FIFO.
- Throughput: 1 result/cycle sustained when out_ready_i=1.
- All outputs are registered or decoded from registered state (pointers/count). The only combinational input→output path is none.
- Reset values: in_ready_o=1, out_valid_o=0, out_result_o=0, out_flags_o=0, out_tag_o=0, fflags_o=0, count_o=0.

## Structure

- fp_pkg: status_t, fp_format_e, and a new function fp_nanbox(fmt, value) returning 64 bits. Also a constant FFLAGS_W=5.
- Sub-module fp_wb_fifo: generic synchronous FIFO (WIDTH, DEPTH; push/pop/full/empty/count). fp_wb_stage instantiates it with WIDTH=64+5+TAG_W and adds boxing, zero-on-empty output gating and fflags logic.

## Test plan

- Reset then single push: result 64'h0000_0000_3F80_0000, flags 5'b00001, tag 3, out_ready_i=1.
  - Next cycle: out_valid_o=1, out_result_o=64'hFFFF_FFFF_3F80_0000, out_tag_o=3.
  - After pop: fflags_o=5'b00001, count_o=0.
- Fill with out_ready_i=0: push 5 back-to-back with DEPTH=4.
  - in_ready_o drops after the 4th push; 5th is held.
  - Raising out_ready_i drains tags 0,1,2,3 in order, then accepts the 5th.
- Streaming with both valid and ready high for 16 cycles: count_o stays 1, every tag is seen exactly once, and pointer wrap is exercised.
- Same-cycle CSR write and retire: fflags_o=5'b10000; write 5'b00100 while a head with flags 5'b01000 pops. Next cycle fflags_o=5'b01100.
- Divide-by-zero result 64'h0000_0000_7F80_0000 with flags 5'b01000 retires → fflags_o bit DZ set; a later retire with flags 0 leaves it set.
- Assert rst_i with 3 entries queued and simultaneous push: next cycle count_o=0, out_valid_o=0, fflags_o=0, outputs 0.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared FP types for the writeback stage: status flags, result formats and NaN-boxing.
package fp_pkg;

  localparam int FFLAGS_W = 5;

  typedef enum logic [1:0] {
    FP32 = 2'd0,
    FP64 = 2'd1,
    FP16 = 2'd2
  } fp_format_e;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;

  // Narrow results are boxed with all-ones upper bits so they read as NaN in 64-bit form.
  function automatic logic [63:0] fp_nanbox(input fp_format_e fmt, input logic [63:0] value);
    case (fmt)
      FP32:    return {32'hFFFF_FFFF, value[31:0]};
      FP16:    return {48'hFFFF_FFFF_FFFF, value[15:0]};
      default: return value;
    endcase
  endfunction

endpackage

// File: rtl/fp_wb_fifo.sv
// Generic in-order synchronous FIFO; rdata shows the head entry and is only meaningful when !empty.
module fp_wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rptr];

  // Storage needs no reset: the empty flag hides any stale contents.
  always_ff @(posedge clk) begin
    if (push_ok && !rst) mem[wptr] <= wdata;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop_ok)  rptr <= rptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fp_wb_stage.sv
// FP writeback stage: NaN-boxes results, queues them in order and accrues sticky fflags at retire.
module fp_wb_stage
  import fp_pkg::*;
#(
  parameter fp_format_e FP_FORMAT = FP32,
  parameter int         DEPTH     = 4,
  parameter int         TAG_W     = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  // Handshakes: a transfer happens on a cycle where valid && ready; valid never waits on ready.
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [63:0]               in_result_i,
  input  status_t                   in_flags_i,
  input  logic [TAG_W-1:0]          in_tag_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [63:0]               out_result_o,
  output status_t                   out_flags_o,
  output logic [TAG_W-1:0]          out_tag_o,
  output logic [FFLAGS_W-1:0]       fflags_o,
  input  logic                      fflags_we_i,
  input  logic [FFLAGS_W-1:0]       fflags_wdata_i,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int WIDTH = 64 + FFLAGS_W + TAG_W;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic [FFLAGS_W-1:0] retire_flags;

  assign in_ready_o  = !full;
  assign out_valid_o = !empty;
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;
  assign wdata       = {fp_nanbox(FP_FORMAT, in_result_i), in_flags_i, in_tag_i};

  fp_wb_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (count_o)
  );

  // Outputs are forced to zero while empty so the consumer never sees stale entries.
  always_comb begin
    out_result_o = '0;
    out_flags_o  = '0;
    out_tag_o    = '0;
    if (!empty) begin
      out_result_o = rdata[WIDTH-1 -: 64];
      out_flags_o  = rdata[TAG_W +: FFLAGS_W];
      out_tag_o    = rdata[TAG_W-1:0];
    end
  end

  assign retire_flags = pop ? FFLAGS_W'(out_flags_o) : '0;

  // A CSR write and a retire in the same cycle both land.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fflags_o <= '0;
    end else begin
      fflags_o <= (fflags_we_i ? fflags_wdata_i : fflags_o) | retire_flags;
    end
  end

endmodule

// File: tb/tb_fp_wb_stage.sv
// Directed bench for fp_wb_stage: per-cycle vector table plus fill/drain and streaming sequences.
module tb_fp_wb_stage;
  import fp_pkg::*;

  localparam int TAG_W = 5;
  localparam int DEPTH = 4;
  localparam int W     = 64 + TAG_W;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [63:0]       in_result;
  status_t           in_flags;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [63:0]       out_result;
  status_t           out_flags;
  logic [TAG_W-1:0]  out_tag;
  logic [4:0]        fflags;
  logic              fflags_we;
  logic [4:0]        fflags_wdata;
  logic [2:0]        count;

  int checks;
  int failures;

  fp_wb_stage #(
    .FP_FORMAT (FP32),
    .DEPTH     (DEPTH),
    .TAG_W     (TAG_W)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_result_i    (in_result),
    .in_flags_i     (in_flags),
    .in_tag_i       (in_tag),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_result_o   (out_result),
    .out_flags_o    (out_flags),
    .out_tag_o      (out_tag),
    .fflags_o       (fflags),
    .fflags_we_i    (fflags_we),
    .fflags_wdata_i (fflags_wdata),
    .count_o        (count)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Vector table: inputs applied this cycle, expected outputs visible during this cycle.
  typedef struct {
    logic        rst;
    logic        iv;
    logic [63:0] res;
    logic [4:0]  fl;
    logic [4:0]  tag;
    logic        ordy;
    logic        we;
    logic [4:0]  wd;
    logic        e_rdy;
    logic        e_ov;
    logic [63:0] e_res;
    logic [4:0]  e_fl;
    logic [4:0]  e_tag;
    logic [4:0]  e_ff;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(
    input logic r, input logic iv, input logic [63:0] res, input logic [4:0] fl,
    input logic [4:0] tag, input logic ordy, input logic we, input logic [4:0] wd,
    input logic e_rdy, input logic e_ov, input logic [63:0] e_res, input logic [4:0] e_fl,
    input logic [4:0] e_tag, input logic [4:0] e_ff, input logic [2:0] e_cnt);
    vec_t v;
    v.rst = r; v.iv = iv; v.res = res; v.fl = fl; v.tag = tag; v.ordy = ordy;
    v.we = we; v.wd = wd; v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_res = e_res;
    v.e_fl = e_fl; v.e_tag = e_tag; v.e_ff = e_ff; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic drive(input logic r, input logic iv, input logic [63:0] res, input logic [4:0] fl,
                       input logic [4:0] tag, input logic ordy, input logic we, input logic [4:0] wd);
    rst = r; in_valid = iv; in_result = res; in_flags = fl; in_tag = tag;
    out_ready = ordy; fflags_we = we; fflags_wdata = wd;
  endtask

  // Scoreboard for the multi-cycle sequences: {boxed result, tag}
  logic [W-1:0] exp_q[$];
  logic [4:0]   next_tag;
  int           pushes;
  int           pops;

  task automatic model_cycle(input logic iv, input logic ordy, input string name);
    logic exp_rdy;
    logic exp_ov;
    @(negedge clk);
    drive(1'b0, iv, {59'd0, next_tag}, 5'd0, next_tag, ordy, 1'b0, 5'd0);
    exp_rdy = (exp_q.size() < DEPTH);
    exp_ov  = (exp_q.size() > 0);
    check({name, "_in_ready"}, 64'(in_ready), 64'(exp_rdy));
    check({name, "_out_valid"}, 64'(out_valid), 64'(exp_ov));
    check({name, "_count"}, 64'(count), 64'(exp_q.size()));
    if (exp_ov) begin
      check({name, "_tag"}, 64'(out_tag), 64'(exp_q[0][TAG_W-1:0]));
      check({name, "_result"}, out_result, exp_q[0][W-1 -: 64]);
    end
    if (exp_ov && ordy) begin
      void'(exp_q.pop_front());
      pops++;
    end
    if (iv && exp_rdy) begin
      exp_q.push_back({32'hFFFF_FFFF, 27'd0, next_tag, next_tag});
      next_tag++;
      pushes++;
    end
  endtask

  initial begin
    checks = 0; failures = 0; next_tag = 5'd0; pushes = 0; pops = 0;
    drive(1'b1, 1'b0, 64'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);

    //            rst iv  res                     fl        tag ordy we wd        rdy ov  e_res                   e_fl      tag ff        cnt
    vecs[0]  = mk(0, 0, 64'd0,                  5'b00000, 0,  0, 0, 5'b00000,  1, 0, 64'd0,                  5'b00000, 0,  5'b00000, 0);
    vecs[1]  = mk(0, 1, 64'h0000_0000_3F80_0000, 5'b00001, 3,  1, 0, 5'b00000,  1, 0, 64'd0,                  5'b00000, 0,  5'b00000, 0);
    vecs[2]  = mk(0, 0, 64'd0,                  5'b00000, 0,  1, 0, 5'b00000,  1, 1, 64'hFFFF_FFFF_3F80_0000, 5'b00001, 3,  5'b00000, 1);
    vecs[3]  = mk(0, 0, 64'd0,                  5'b00000, 0,  0, 0, 5'b00000,  1, 0, 64'd0,                  5'b00000, 0,  5'b00001, 0);
    vecs[4]  = mk(0, 1, 64'h1234_5678_4000_0000, 5'b01000, 7,  0, 1, 5'b10000,  1, 0, 64'd0,                  5'b00000, 0,  5'b00001, 0);
    vecs[5]  = mk(0, 0, 64'd0,                  5'b00000, 0,  0, 0, 5'b00000,  1, 1, 64'hFFFF_FFFF_4000_0000, 5'b01000, 7,  5'b10000, 1);
    vecs[6]  = mk(0, 0, 64'd0,                  5'b00000, 0,  1, 1, 5'b00100,  1, 1, 64'hFFFF_FFFF_4000_0000, 5'b01000, 7,  5'b10000, 1);
    vecs[7]  = mk(0, 0, 64'd0,                  5'b00000, 0,  0, 0, 5'b00000,  1, 0, 64'd0,                  5'b00000, 0,  5'b01100, 0);
    vecs[8]  = mk(0, 1, 64'h0000_0000_7F80_0000, 5'b01000, 9,  1, 1, 5'b00000,  1, 0, 64'd0,                  5'b00000, 0,  5'b01100, 0);
    vecs[9]  = mk(0, 1, 64'h0000_0000_3F80_0000, 5'b00000, 10, 1, 0, 5'b00000,  1, 1, 64'hFFFF_FFFF_7F80_0000, 5'b01000, 9,  5'b00000, 1);
    vecs[10] = mk(0, 0, 64'd0,                  5'b00000, 0,  1, 0, 5'b00000,  1, 1, 64'hFFFF_FFFF_3F80_0000, 5'b00000, 10, 5'b01000, 1);
    vecs[11] = mk(0, 0, 64'd0,                  5'b00000, 0,  0, 0, 5'b00000,  1, 0, 64'd0,                  5'b00000, 0,  5'b01000, 0);
    vecs[12] = mk(0, 1, 64'h0000_0000_0000_0001, 5'b00010, 1,  0, 0, 5'b00000,  1, 0, 64'd0,                  5'b00000, 0,  5'b01000, 0);
    vecs[13] = mk(0, 1, 64'h0000_0000_0000_0002, 5'b00000, 2,  0, 0, 5'b00000,  1, 1, 64'hFFFF_FFFF_0000_0001, 5'b00010, 1,  5'b01000, 1);
    vecs[14] = mk(0, 1, 64'h0000_0000_0000_0003, 5'b00000, 4,  0, 0, 5'b00000,  1, 1, 64'hFFFF_FFFF_0000_0001, 5'b00010, 1,  5'b01000, 2);
    vecs[15] = mk(1, 1, 64'h0000_0000_0000_0004, 5'b11111, 5,  1, 1, 5'b11111,  1, 1, 64'hFFFF_FFFF_0000_0001, 5'b00010, 1,  5'b01000, 3);
    vecs[16] = mk(0, 0, 64'd0,                  5'b00000, 0,  0, 0, 5'b00000,  1, 0, 64'd0,                  5'b00000, 0,  5'b00000, 0);

    repeat (2) @(posedge clk);

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].iv, vecs[i].res, vecs[i].fl, vecs[i].tag,
            vecs[i].ordy, vecs[i].we, vecs[i].wd);
      check($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].e_rdy));
      check($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
      check($sformatf("v%0d_out_result", i), out_result, vecs[i].e_res);
      check($sformatf("v%0d_out_flags", i), 64'(out_flags), 64'(vecs[i].e_fl));
      check($sformatf("v%0d_out_tag", i), 64'(out_tag), 64'(vecs[i].e_tag));
      check($sformatf("v%0d_fflags", i), 64'(fflags), 64'(vecs[i].e_ff));
      check($sformatf("v%0d_count", i), 64'(count), 64'(vecs[i].e_cnt));
    end

    // Fill with consumer stalled: tags 0..3 enter, tag 4 is held while full.
    for (int i = 0; i < 6; i++) model_cycle(1'b1, 1'b0, "fill");
    check("fill_held_tag", 64'(next_tag), 64'd4);
    // Drain: full cycle refuses push even while popping; tag 4 enters afterwards.
    for (int i = 0; i < 8; i++) model_cycle(next_tag < 5, 1'b1, "drain");
    check("drain_pops", 64'(pops), 64'd5);

    // Streaming: steady occupancy of one entry, pointers wrap several times.
    for (int i = 0; i < 17; i++) model_cycle(1'b1, 1'b1, "stream");
    for (int i = 0; i < 2; i++) model_cycle(1'b0, 1'b1, "stream_end");
    check("stream_balance", 64'(pops), 64'(pushes));
    check("stream_pushes", 64'(pushes), 64'd22);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
